// File: rtl/lcd_frame_writer.sv
// HD44780 16x2 character LCD writer: one-time power-up init, then continuous
// refresh of two 16-character rows captured as a coherent snapshot per frame.
module lcd_frame_writer #(
  parameter int POWERUP_CYC = 400000,
  parameter int EN_CYC      = 10,
  parameter int CMD_CYC     = 500,
  parameter int CLR_CYC     = 20000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] top,
  input  logic [127:0] bottom,
  output logic         lcd_rs,
  output logic         lcd_rw,
  output logic         lcd_en,
  output logic [7:0]   lcd_data,
  output logic         init_done,
  output logic         frame_done,
  output logic [2:0]   dbg_state
);

  localparam int MAX_A   = (POWERUP_CYC > CLR_CYC) ? POWERUP_CYC : CLR_CYC;
  localparam int MAX_B   = (CMD_CYC > EN_CYC) ? CMD_CYC : EN_CYC;
  localparam int MAX_CYC = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW      = $clog2(MAX_CYC + 1);

  localparam logic [CW-1:0] PWR_LAST = CW'(POWERUP_CYC - 1);
  localparam logic [CW-1:0] EN_LAST  = CW'(EN_CYC - 1);
  localparam logic [CW-1:0] CMD_LAST = CW'(CMD_CYC - 1);
  localparam logic [CW-1:0] CLR_LAST = CW'(CLR_CYC - 1);

  typedef enum logic [2:0] {
    S_PWRUP = 3'd0,
    S_INIT  = 3'd1,
    S_ADDR0 = 3'd2,
    S_CHAR0 = 3'd3,
    S_ADDR1 = 3'd4,
    S_CHAR1 = 3'd5
  } state_e;

  // Each byte walks SETUP (1 cycle) -> PULSE (EN_CYC) -> SETTLE (W cycles).
  typedef enum logic [1:0] {
    PH_SETUP  = 2'd0,
    PH_PULSE  = 2'd1,
    PH_SETTLE = 2'd2
  } phase_e;

  state_e         state_q, state_d;
  phase_e         phase_q, phase_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [1:0]     idx_q, idx_d;
  logic [3:0]     col_q, col_d;
  logic [127:0]   shadow_top_q, shadow_top_d;
  logic [127:0]   shadow_bot_q, shadow_bot_d;
  logic           init_done_q, init_done_d;
  logic           frame_done_q, frame_done_d;

  logic           cur_rs;
  logic [7:0]     cur_byte;
  logic [7:0]     raw_char;
  logic [CW-1:0]  settle_last;
  logic           byte_done;

  // Byte on the bus is a pure function of state, so it holds steady for the
  // whole setup/pulse/settle window of that byte.
  always_comb begin
    cur_rs   = 1'b0;
    cur_byte = 8'h00;
    raw_char = 8'h00;
    case (state_q)
      S_INIT: begin
        case (idx_q)
          2'd0:    cur_byte = 8'h38;
          2'd1:    cur_byte = 8'h0C;
          2'd2:    cur_byte = 8'h01;
          default: cur_byte = 8'h06;
        endcase
      end
      S_ADDR0: cur_byte = 8'h80;
      S_ADDR1: cur_byte = 8'hC0;
      S_CHAR0: begin
        cur_rs   = 1'b1;
        raw_char = shadow_top_q[{~col_q, 3'b000} +: 8];
        cur_byte = (raw_char == 8'h00) ? 8'h20 : raw_char;
      end
      S_CHAR1: begin
        cur_rs   = 1'b1;
        raw_char = shadow_bot_q[{~col_q, 3'b000} +: 8];
        cur_byte = (raw_char == 8'h00) ? 8'h20 : raw_char;
      end
      default: begin
        cur_rs   = 1'b0;
        cur_byte = 8'h00;
      end
    endcase
    settle_last = (!cur_rs && cur_byte == 8'h01) ? CLR_LAST : CMD_LAST;
  end

  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    col_d        = col_q;
    shadow_top_d = shadow_top_q;
    shadow_bot_d = shadow_bot_q;
    init_done_d  = init_done_q;
    frame_done_d = 1'b0;
    byte_done    = 1'b0;

    if (state_q == S_PWRUP) begin
      if (cnt_q == PWR_LAST) begin
        state_d = S_INIT;
        phase_d = PH_SETUP;
        idx_d   = 2'd0;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else begin
      case (phase_q)
        PH_SETUP: begin
          phase_d = PH_PULSE;
          cnt_d   = '0;
        end
        PH_PULSE: begin
          if (cnt_q == EN_LAST) begin
            phase_d = PH_SETTLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: begin
          if (cnt_q == settle_last) begin
            byte_done = 1'b1;
            phase_d   = PH_SETUP;
            cnt_d     = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      endcase
    end

    // Snapshot both rows only on entry to ADDR0 so a frame never mixes content.
    if (byte_done) begin
      case (state_q)
        S_INIT: begin
          if (idx_q == 2'd3) begin
            state_d      = S_ADDR0;
            init_done_d  = 1'b1;
            shadow_top_d = top;
            shadow_bot_d = bottom;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
        S_ADDR0: begin
          state_d = S_CHAR0;
          col_d   = 4'd0;
        end
        S_CHAR0: begin
          if (col_q == 4'd15) begin
            state_d = S_ADDR1;
            col_d   = 4'd0;
          end else begin
            col_d = col_q + 4'd1;
          end
        end
        S_ADDR1: begin
          state_d = S_CHAR1;
          col_d   = 4'd0;
        end
        S_CHAR1: begin
          if (col_q == 4'd15) begin
            state_d      = S_ADDR0;
            col_d        = 4'd0;
            frame_done_d = 1'b1;
            shadow_top_d = top;
            shadow_bot_d = bottom;
          end else begin
            col_d = col_q + 4'd1;
          end
        end
        default: state_d = S_PWRUP;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_PWRUP;
      phase_q      <= PH_SETUP;
      cnt_q        <= '0;
      idx_q        <= 2'd0;
      col_q        <= 4'd0;
      shadow_top_q <= '0;
      shadow_bot_q <= '0;
      init_done_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      col_q        <= col_d;
      shadow_top_q <= shadow_top_d;
      shadow_bot_q <= shadow_bot_d;
      init_done_q  <= init_done_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign lcd_rs     = cur_rs;
  assign lcd_rw     = 1'b0;
  assign lcd_en     = (state_q != S_PWRUP) && (phase_q == PH_PULSE);
  assign lcd_data   = cur_byte;
  assign init_done  = init_done_q;
  assign frame_done = frame_done_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_lcd_frame_writer.sv
// Bench for lcd_frame_writer: byte-schedule model built from the LCD protocol
// rules, checked every cycle, plus literal pins for init, frame content and timing.
module tb_lcd_frame_writer;

  localparam int P   = 20;
  localparam int E   = 2;
  localparam int CMD = 3;
  localparam int CLR = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [127:0] top = '0;
  logic [127:0] bottom = '0;
  logic         lcd_rs, lcd_rw, lcd_en;
  logic [7:0]   lcd_data;
  logic         init_done, frame_done;
  logic [2:0]   dbg_state;

  always #5 clk = ~clk;

  lcd_frame_writer #(
    .POWERUP_CYC(P), .EN_CYC(E), .CMD_CYC(CMD), .CLR_CYC(CLR)
  ) dut (
    .clk(clk), .rst(rst), .top(top), .bottom(bottom),
    .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_en(lcd_en), .lcd_data(lcd_data),
    .init_done(init_done), .frame_done(frame_done), .dbg_state(dbg_state)
  );

  int checks = 0;
  int failures = 0;

  // Model: queue of {rs,data} bytes still to be sent, offset inside current byte.
  logic [8:0] exp_q[$];
  int m_t = 0;
  int m_off = 0;
  bit m_seen = 0, m_init_pushed = 0, m_init_done = 0, m_fd_next = 0;

  // Observations of the DUT bus, used by the literal pins and stimulus timing.
  logic [8:0] cap[$];
  int cap_t[$];
  int fd_mt[$];
  int widths[$];
  int gaps[$];
  int init_rise_t = -1;
  int high_run = 0, low_run = 0, fr_pos = 0;
  bit had_pulse = 0, prev_en = 0, prev_init = 0, rose = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0d actual=%0h expected=%0h", name, m_t, act, exp);
    end
  endtask

  function automatic logic [127:0] row(input string s);
    logic [127:0] r = '0;
    for (int i = 0; i < s.len() && i < 16; i++) r[(15 - i) * 8 +: 8] = s[i];
    return r;
  endfunction

  function automatic logic [8:0] filt(input logic [7:0] b);
    return {1'b1, (b == 8'h00) ? 8'h20 : b};
  endfunction

  // Hand-written first frame: "HANGMAN" on row 0, six underscores centred on row 1.
  function automatic logic [8:0] f1(input int i);
    if (i == 0) return 9'h080;
    if (i == 1) return 9'h148;
    if (i == 2) return 9'h141;
    if (i == 3) return 9'h14E;
    if (i == 4) return 9'h147;
    if (i == 5) return 9'h14D;
    if (i == 6) return 9'h141;
    if (i == 7) return 9'h14E;
    if (i <= 16) return 9'h120;
    if (i == 17) return 9'h0C0;
    if (i >= 23 && i <= 28) return 9'h15F;
    return 9'h120;
  endfunction

  task automatic model_and_check();
    logic [8:0] b;
    int w;
    logic e_rs, e_en, e_fd, e_id;
    logic [7:0] e_data;
    e_rs = 0; e_en = 0; e_fd = 0; e_id = 0; e_data = 8'h00;
    if (rst) begin
      m_seen = 1; m_t = 0; m_off = 0; exp_q.delete();
      m_init_pushed = 0; m_init_done = 0; m_fd_next = 0;
      cap.delete(); cap_t.delete(); fd_mt.delete(); widths.delete(); gaps.delete();
      init_rise_t = -1; high_run = 0; low_run = 0; fr_pos = 0; had_pulse = 0; rose = 0;
    end else begin
      if (!m_seen) return;
      m_t++;
      e_fd = m_fd_next;
      m_fd_next = 0;
      e_id = m_init_done;
      if (m_t >= P) begin
        if (exp_q.size() == 0) begin
          if (!m_init_pushed) begin
            exp_q = '{9'h038, 9'h00C, 9'h001, 9'h006};
            m_init_pushed = 1;
          end else begin
            exp_q.push_back(9'h080);
            for (int c = 0; c < 16; c++) exp_q.push_back(filt(top[(15 - c) * 8 +: 8]));
            exp_q.push_back(9'h0C0);
            for (int c = 0; c < 16; c++) exp_q.push_back(filt(bottom[(15 - c) * 8 +: 8]));
          end
        end
        b = exp_q[0];
        w = (b == 9'h001) ? CLR : CMD;
        e_rs = b[8];
        e_data = b[7:0];
        e_en = (m_off >= 1 && m_off <= E);
        m_off++;
        if (m_off == 1 + E + w) begin
          void'(exp_q.pop_front());
          m_off = 0;
          if (exp_q.size() == 0) begin
            if (m_init_done) m_fd_next = 1;
            else m_init_done = 1;
          end
        end
      end
    end
    chk("lcd_rs", 32'(lcd_rs), 32'(e_rs));
    chk("lcd_rw", 32'(lcd_rw), 32'(0));
    chk("lcd_en", 32'(lcd_en), 32'(e_en));
    chk("lcd_data", 32'(lcd_data), 32'(e_data));
    chk("init_done", 32'(init_done), 32'(e_id));
    chk("frame_done", 32'(frame_done), 32'(e_fd));

    rose = 0;
    if (!rst) begin
      if (lcd_en && !prev_en) begin
        cap.push_back({lcd_rs, lcd_data});
        cap_t.push_back(m_t);
        if (had_pulse) gaps.push_back(low_run);
        if ({lcd_rs, lcd_data} == 9'h080) fr_pos = 0;
        else fr_pos++;
        rose = 1;
        high_run = 0;
      end
      if (!lcd_en && prev_en) begin
        widths.push_back(high_run);
        had_pulse = 1;
        low_run = 0;
      end
      if (lcd_en) high_run++;
      else low_run++;
      if (frame_done) fd_mt.push_back(m_t);
      if (init_done && !prev_init) init_rise_t = m_t;
    end
    prev_en = lcd_en;
    prev_init = init_done;
  endtask

  task automatic step();
    @(negedge clk);
    model_and_check();
  endtask

  task automatic run_until_fd(input int n, input int budget);
    while (fd_mt.size() < n && budget > 0) begin
      step();
      budget--;
    end
    chk("fd_timeout", 32'(fd_mt.size() >= n), 32'(1));
  endtask

  task automatic pin_init();
    chk("first_en_rise", 32'(cap_t[0]), 32'(P + 1));
    chk("init_b0", 32'(cap[0]), 32'h038);
    chk("init_b1", 32'(cap[1]), 32'h00C);
    chk("init_b2", 32'(cap[2]), 32'h001);
    chk("init_b3", 32'(cap[3]), 32'h006);
    for (int i = 0; i < 4; i++) chk("en_width", 32'(widths[i]), 32'(2));
    // Low run between strobes = settle + next byte's setup cycle.
    chk("gap_38", 32'(gaps[0]), 32'(4));
    chk("gap_0c", 32'(gaps[1]), 32'(4));
    chk("gap_01", 32'(gaps[2]), 32'(9));
    chk("init_rise", 32'(init_rise_t), 32'(49));
  endtask

  task automatic rand_rows();
    for (int c = 0; c < 16; c++) begin
      top[c * 8 +: 8]    = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
      bottom[c * 8 +: 8] = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
    end
  endtask

  initial begin
    int budget;
    top = row("HANGMAN");
    bottom = 128'h00000000005F5F5F5F5F5F0000000000;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;

    // Power-up, init, first frame.
    run_until_fd(1, 2000);
    if (cap.size() >= 38 && fd_mt.size() >= 1) begin
      pin_init();
      for (int i = 0; i < 34; i++) chk("frame1_byte", 32'(cap[4 + i]), 32'(f1(i)));
      chk("frame1_done_t", 32'(fd_mt[0]), 32'(253));
    end

    // Change rows on the 5th character strobe of row 0.
    budget = 500;
    while (!(rose && fr_pos == 5) && budget > 0) begin
      step();
      budget--;
    end
    chk("strobe5_timeout", 32'(budget > 0), 32'(1));
    top = row("Win");
    rand_rows();
    top = row("Win");
    run_until_fd(3, 1000);
    if (cap.size() >= 4 + 34 * 3) begin
      for (int i = 0; i < 34; i++) chk("old_frame_byte", 32'(cap[38 + i]), 32'(f1(i)));
      chk("win_w", 32'(cap[73]), 32'h157);
      chk("win_i", 32'(cap[74]), 32'h169);
      chk("win_n", 32'(cap[75]), 32'h16E);
      chk("win_pad", 32'(cap[76]), 32'h120);
    end

    // Random rows changed at random points.
    for (int k = 0; k < 6; k++) begin
      int n = $urandom_range(1, 300);
      for (int j = 0; j < n; j++) step();
      rand_rows();
    end

    // Reset while a row-1 character strobe is high.
    budget = 500;
    while (!(fr_pos >= 18 && lcd_en) && budget > 0) begin
      step();
      budget--;
    end
    chk("char1_timeout", 32'(budget > 0), 32'(1));
    rst = 1'b1;
    step();
    chk("rst_en_low", 32'(lcd_en), 32'(0));
    chk("rst_init_low", 32'(init_done), 32'(0));
    rst = 1'b0;
    rand_rows();

    // Full re-init then back-to-back frames with unchanged rows.
    run_until_fd(4, 3000);
    if (cap.size() >= 4 + 34 * 4 && fd_mt.size() >= 4) begin
      pin_init();
      chk("reinit_addr0", 32'(cap[4]), 32'h080);
      for (int k = 0; k < 3; k++) chk("fd_spacing", 32'(fd_mt[k + 1] - fd_mt[k]), 32'(204));
      for (int k = 1; k < 4; k++)
        for (int i = 0; i < 34; i++)
          chk("repeat_frame", 32'(cap[4 + 34 * k + i]), 32'(cap[4 + i]));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
